// File: rtl/disp_key_ctrl.sv
// disp_key_ctrl: debounced front-panel keys driving the 7-segment display mode and peak index
// Ports: clk; rstn (async, active-low); key_mode/key_next/key_prev raw buttons (0 = pressed);
//   detect_done, peak_cnt from the peak detector; disp_mode, disp_peak_idx to the display driver;
//   key_evt one-cycle diagnostic pulse per accepted key event.
// Optional macro KEY_AUTO_REPEAT_EN: auto-repeat on next/prev while held.
module disp_key_ctrl #(
  parameter int DEB_CYCLES          = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int REPEAT_CYCLES       = 5_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_mode,
  input  logic       key_next,
  input  logic       key_prev,
  input  logic       detect_done,
  input  logic [3:0] peak_cnt,
  output logic [1:0] disp_mode,
  output logic [2:0] disp_peak_idx,
  output logic       key_evt
);
  localparam int CW = $clog2(DEB_CYCLES);
  typedef enum logic [1:0] {IDLE = 2'b00, TIME = 2'b01, COORD = 2'b10, VALUE = 2'b11} mode_e;
  // Key bit order everywhere: 0 = mode, 1 = next, 2 = prev.
  logic [2:0] s1_q, s2_q, s3_q, deb_q, deb_d, debr_q, ev_q, ev_d;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  mode_e mode_q, mode_d;
  logic [2:0] idx_q, idx_d, idx_nx, idx_pv;
  logic [3:0] n_c;
  // s3 is a retiming stage after the 2-FF synchroniser so acceptance lands at DEB_CYCLES+2.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = (s3_q[k] == deb_q[k] || cnt_q[k] == CW'(DEB_CYCLES - 1)) ? '0 : cnt_q[k] + 1'b1;
      deb_d[k] = (s3_q[k] != deb_q[k] && cnt_q[k] == CW'(DEB_CYCLES - 1)) ? s3_q[k] : deb_q[k];
    end
  end
`ifdef KEY_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY_CYCLES);
  logic [2:1][RW-1:0] rc_q, rc_d;
  logic [2:1] ph_q, ph_d, rpt;
  // ph selects the initial delay (0) or the steady repeat interval (1).
  always_comb begin
    for (int k = 1; k < 3; k++) begin
      rpt[k]  = !deb_q[k] && (ph_q[k] ? rc_q[k] == RW'(REPEAT_CYCLES - 1)
                                      : rc_q[k] == RW'(REPEAT_DELAY_CYCLES - 1));
      rc_d[k] = (deb_q[k] || rpt[k]) ? '0 : rc_q[k] + 1'b1;
      ph_d[k] = !deb_q[k] && (ph_q[k] || rpt[k]);
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rc_q <= '0;
      ph_q <= '0;
    end else begin
      rc_q <= rc_d;
      ph_q <= ph_d;
    end
  assign ev_d = (debr_q & ~deb_q) | {rpt, 1'b0};
`else
  assign ev_d = debr_q & ~deb_q;
`endif
  assign n_c = (peak_cnt > 4'd8) ? 4'd8 : peak_cnt;
  always_comb begin
    idx_nx = ({1'b0, idx_q} + 4'd1 == n_c) ? 3'd0 : idx_q + 3'd1;
    idx_pv = (idx_q == 3'd0) ? 3'(n_c - 4'd1) : idx_q - 3'd1;
    mode_d = !detect_done      ? IDLE :
             (mode_q == IDLE)  ? TIME :
             !ev_q[0]          ? mode_q :
             (mode_q == VALUE) ? TIME : mode_e'(mode_q + 2'd1);
    // Out-of-range index (peak_cnt shrank, or zero peaks) snaps to 0; next+prev together cancel.
    idx_d = (!detect_done || {1'b0, idx_q} >= n_c) ? 3'd0 :
            (mode_q[1] && ev_q[1] != ev_q[2])     ? (ev_q[1] ? idx_nx : idx_pv) : idx_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1_q   <= '1;
      s2_q   <= '1;
      s3_q   <= '1;
      deb_q  <= '1;
      debr_q <= '1;
      cnt_q  <= '0;
      ev_q   <= '0;
      mode_q <= IDLE;
      idx_q  <= '0;
    end else begin
      s1_q   <= {key_prev, key_next, key_mode};
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      deb_q  <= deb_d;
      debr_q <= deb_q;
      cnt_q  <= cnt_d;
      ev_q   <= ev_d;
      mode_q <= mode_d;
      idx_q  <= idx_d;
    end
  assign disp_mode     = mode_q;
  assign disp_peak_idx = idx_q;
  assign key_evt       = |ev_q;
endmodule

// File: tb/tb_disp_key_ctrl.sv
// tb_disp_key_ctrl: scoreboard bench for disp_key_ctrl with DEB_CYCLES=16
module tb_disp_key_ctrl;
  logic clk = 1'b0, rstn = 1'b0;
  logic key_mode = 1'b1, key_next = 1'b1, key_prev = 1'b1, detect_done = 1'b0;
  logic [3:0] peak_cnt = 4'd0;
  logic [1:0] disp_mode;
  logic [2:0] disp_peak_idx;
  logic key_evt;
  int checks = 0, failures = 0;
  int m_mode = 0, m_idx = 0;
  logic [4:0] sb[$];

  disp_key_ctrl #(.DEB_CYCLES(16), .REPEAT_DELAY_CYCLES(100), .REPEAT_CYCLES(20)) dut (
    .clk(clk), .rstn(rstn), .key_mode(key_mode), .key_next(key_next), .key_prev(key_prev),
    .detect_done(detect_done), .peak_cnt(peak_cnt), .disp_mode(disp_mode),
    .disp_peak_idx(disp_peak_idx), .key_evt(key_evt)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] model_out();
    return {m_mode[1:0], m_idx[2:0]};
  endfunction

  function automatic void model_key(input logic m, input logic n, input logic p);
    int nn;
    nn = (peak_cnt > 4'd8) ? 8 : int'(peak_cnt);
    if (m_mode == 0) return;
    if (m_mode >= 2 && n != p && nn > 0) m_idx = n ? (m_idx + 1) % nn : (m_idx == 0 ? nn - 1 : m_idx - 1);
    if (m) m_mode = (m_mode == 3) ? 1 : m_mode + 1;
  endfunction

  task automatic set_done(input logic v);
    detect_done = v;
    if (!v) begin m_mode = 0; m_idx = 0; end else if (m_mode == 0) m_mode = 1;
    @(negedge clk);
    checks++;
    if ({disp_mode, disp_peak_idx} !== model_out()) begin
      failures++; $display("FAIL set_done got=%b exp=%b", {disp_mode, disp_peak_idx}, model_out());
    end
  endtask

  task automatic set_peak(input logic [3:0] v);
    int nn;
    peak_cnt = v;
    nn = (v > 4'd8) ? 8 : int'(v);
    if (m_idx >= nn) m_idx = 0;
    @(negedge clk);
    checks++;
    if (disp_peak_idx !== 3'(m_idx)) begin
      failures++; $display("FAIL set_peak idx got=%0d exp=%0d", disp_peak_idx, m_idx);
    end
  endtask

  task automatic press(input logic m, input logic n, input logic p);
    int pulses;
    logic [4:0] e;
    model_key(m, n, p);
    sb.push_back(model_out());
    key_mode = ~m; key_next = ~n; key_prev = ~p;
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (key_evt) begin
        pulses++;
        if (sb.size() > 0) begin
          @(negedge clk);
          e = sb.pop_front();
          checks++;
          if ({disp_mode, disp_peak_idx} !== e) begin
            failures++; $display("FAIL press_result got=%b exp=%b", {disp_mode, disp_peak_idx}, e);
          end
        end
      end
    end
    key_mode = 1'b1; key_next = 1'b1; key_prev = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (key_evt) pulses++;
    end
    checks++;
    if (pulses !== 1 || sb.size() != 0) begin
      failures++; $display("FAIL press_events pulses=%0d exp=1 pending=%0d", pulses, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_evt, disp_mode, disp_peak_idx} !== 6'd0) begin
      failures++; $display("FAIL reset_hold got=%b exp=0", {key_evt, disp_mode, disp_peak_idx});
    end
    rstn = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      checks++;
      if ({key_evt, disp_mode, disp_peak_idx} !== 6'd0) begin
        failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=0", i, {key_evt, disp_mode, disp_peak_idx});
      end
    end
  endtask

  task automatic test_held_reset;
    int pulses, at;
    detect_done = 1'b1;
    key_mode = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    m_mode = 1; m_idx = 0;
    @(negedge clk);
    checks++;
    if ({disp_mode, disp_peak_idx} !== model_out()) begin
      failures++; $display("FAIL held_reset_time got=%b exp=%b", {disp_mode, disp_peak_idx}, model_out());
    end
    pulses = 0; at = -1;
    for (int i = 1; i < 60; i++) begin
      @(negedge clk);
      if (key_evt) begin pulses++; if (at < 0) at = i; end
    end
    key_mode = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (pulses !== 1 || at !== 19) begin
      failures++; $display("FAIL held_reset_event pulses=%0d at=%0d exp=1 at 19", pulses, at);
    end
    model_key(1'b1, 1'b0, 1'b0);
    checks++;
    if ({disp_mode, disp_peak_idx} !== model_out()) begin
      failures++; $display("FAIL held_reset_mode got=%b exp=%b", {disp_mode, disp_peak_idx}, model_out());
    end
  endtask

  task automatic test_latency_glitch;
    int pulses;
    key_mode = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (disp_mode !== 2'b01 || key_evt !== 1'b1) begin
      failures++; $display("FAIL latency_edge19 mode=%b evt=%b exp mode=01 evt=1", disp_mode, key_evt);
    end
    @(negedge clk);
    model_key(1'b1, 1'b0, 1'b0);
    checks++;
    if (disp_mode !== 2'b10) begin
      failures++; $display("FAIL latency_edge20 mode=%b exp=10", disp_mode);
    end
    repeat (19) @(negedge clk);
    key_mode = 1'b1;
    repeat (30) @(negedge clk);
    key_mode = 1'b0;
    repeat (10) @(negedge clk);
    key_mode = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_evt) pulses++;
    end
    checks++;
    if (pulses !== 0 || {disp_mode, disp_peak_idx} !== model_out()) begin
      failures++; $display("FAIL glitch pulses=%0d out=%b exp 0 and %b", pulses, {disp_mode, disp_peak_idx}, model_out());
    end
  endtask

  task automatic test_index;
    set_peak(4'd3);
    repeat (4) press(1'b0, 1'b1, 1'b0);
    repeat (2) press(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_zero_and_shrink;
    set_peak(4'd0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    set_peak(4'd8);
    repeat (5) press(1'b0, 1'b1, 1'b0);
    peak_cnt = 4'd4;
    checks++;
    if (disp_peak_idx !== 3'd5) begin
      failures++; $display("FAIL shrink_before idx=%0d exp=5", disp_peak_idx);
    end
    set_peak(4'd4);
  endtask

  task automatic test_simultaneous;
    set_peak(4'd8);
    repeat (2) press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    press(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_done_drop;
    set_done(1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
  endtask

`ifdef KEY_AUTO_REPEAT_EN
  task automatic test_auto_repeat;
    int pulses, t;
    set_done(1'b1);
    press(1'b1, 1'b0, 1'b0);
    set_peak(4'd8);
    key_next = 1'b0;
    t = 0;
    while (!key_evt && t < 60) begin @(negedge clk); t++; end
    pulses = key_evt ? 1 : 0;
    for (int i = 0; i < 188; i++) begin @(negedge clk); if (key_evt) pulses++; end
    key_next = 1'b1;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (key_evt) pulses++; end
    m_idx = (m_idx + 7) % 8;
    checks++;
    if (pulses !== 7 || disp_peak_idx !== 3'(m_idx)) begin
      failures++; $display("FAIL auto_repeat pulses=%0d idx=%0d exp 7 and %0d", pulses, disp_peak_idx, m_idx);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_held_reset;
    set_done(1'b0);
    set_done(1'b1);
    test_latency_glitch;
    test_index;
    test_zero_and_shrink;
    test_simultaneous;
    test_done_drop;
`ifdef KEY_AUTO_REPEAT_EN
    test_auto_repeat;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/disp_key_ctrl.md
# disp_key_ctrl

Front-panel key controller that generates the display-selection inputs consumed by the 7-segment display driver. It synchronises and debounces three raw active-low push buttons and turns them into single-cycle press events. A mode state machine then drives `disp_mode` and `disp_peak_idx` from those events, gated by the peak detector's completion status. The block sits between the board keys, the peak-detection core and the segment display driver.

## Interface
- `DEB_CYCLES`, 1_000_000: consecutive stable cycles required to accept a key level change (20 ms at 50 MHz).
- `REPEAT_DELAY_CYCLES`, 25_000_000: hold time before the first auto-repeat (only with the auto-repeat macro).
- `REPEAT_CYCLES`, 5_000_000: interval between subsequent auto-repeats (only with the auto-repeat macro).

- `clk` in 1: system clock.
- `rstn` in 1: asynchronous, active-low reset.
- `key_mode` in 1: raw button, 0 = pressed; cycles the display mode.
- `key_next` in 1: raw button, 0 = pressed; selects the next peak.
- `key_prev` in 1: raw button, 0 = pressed; selects the previous peak.
- `detect_done` in 1: level, 1 = peak search finished and results valid.
- `peak_cnt` in 4: number of valid peaks, 0..8; values above 8 are treated as 8.
- `disp_mode` out 2: 00 idle/zeros, 01 detect time, 10 row/col, 11 peak value.
- `disp_peak_idx` out 3: index of the peak being displayed.
- `key_evt` out 1: one-cycle pulse on any accepted key event (diagnostic).

## Operation
- **Per-key pipeline:**
  - 2-FF synchroniser, reset to 1.
  - Debounced state `deb`, reset to 1.
  - Counter `cnt`:
    - When `sync != deb`, `cnt` increments.
    - When `sync == deb`, `cnt` clears.
    - When `cnt` reaches `DEB_CYCLES-1` while still differing, `deb` takes the value of `sync` and `cnt` clears.
  - A press event is registered one cycle after `deb` goes 1→0. Releases generate no event.
- **Mode FSM states:** IDLE (00), TIME (01), COORD (10), VALUE (11).
  - Any state with `detect_done=0` → IDLE; `disp_peak_idx` ← 0.
  - IDLE with `detect_done=1` → TIME. Key events in the same cycle are discarded.
  - Mode press cycles TIME → COORD → VALUE → TIME.
  - All key events are ignored in IDLE.
- **Peak index:** updates only in COORD or VALUE.
  - Next press: `idx = (idx+1) mod N`, where N = min(`peak_cnt`, 8).
  - Prev press: `idx = idx-1`; from 0 it wraps to N-1.
  - N = 0: `idx` holds 0.
- **Simultaneous events:**
  - Next and prev in the same cycle cancel; neither is applied, and `key_evt` still pulses.
  - Mode together with next/prev: the mode change and the index change are both applied.
- **Index range:** if `idx >= N` at any time (because `peak_cnt` dropped), `idx` ← 0 on the next edge.
- **Register widths:** `cnt` is sized by `$clog2(DEB_CYCLES)`; repeat counters by `$clog2(REPEAT_DELAY_CYCLES)`. No counter may overflow.

## Timing
- **Reset values:** `disp_mode`=00, `disp_peak_idx`=0, `key_evt`=0, all `deb`/sync=1, all counters 0. Reset asserts asynchronously and deasserts synchronously to `clk` via the standard reset path.
- **Key latency:**
  - Raw edge first sampled at edge 0.
  - `deb` flips at edge `DEB_CYCLES+2`.
  - Event pulse high after edge `DEB_CYCLES+3`.
  - `disp_*` updates at edge `DEB_CYCLES+4`.
- **Glitch filtering:** a raw glitch shorter than `DEB_CYCLES` cycles produces no event.
- **`detect_done` path:** registered; `disp_mode` changes on the first edge that samples the new level. There is no synchroniser on this path (same clock domain).
- **Held key across reset:** `deb` restarts at released, so a key held through reset release yields exactly one press event `DEB_CYCLES+3` cycles after release.
- **Reset mid-debounce:** a reset during debounce discards the partial count.

## Configuration
- Macro `KEY_AUTO_REPEAT_EN` controls auto-repeat on the next/prev keys.
- **Defined:** while next/prev `deb` stays 0, an extra event fires after `REPEAT_DELAY_CYCLES` cycles, then every `REPEAT_CYCLES` cycles until release. The mode key never repeats.
- **Undefined:** exactly one event per press; the repeat counters and parameters are unused and not synthesised.

## Test plan
- Reset release with all keys high and `detect_done`=0 → `disp_mode`=00, `idx`=0, no `key_evt` for 1000 cycles.
- With `DEB_CYCLES`=16, `detect_done`=1: `key_mode` low for 40 cycles → `disp_mode` goes 01→10 exactly 20 cycles after the first sampled low. A 10-cycle low glitch → no change.
- In COORD with `peak_cnt`=3: next×4 → `idx` sequence 1,2,0,1. Then prev×2 → 0,2.
- `peak_cnt`=0: next/prev presses → `idx` stays 0. Then `idx`=5 with `peak_cnt` dropped 8→4 → `idx`=0 one edge later.
- Next and prev pressed in the same cycle → `idx` unchanged, one `key_evt` pulse. Dropping `detect_done` while in VALUE → 00 and `idx` 0 on the next edge.
- With `KEY_AUTO_REPEAT_EN`, `REPEAT_DELAY_CYCLES`=100, `REPEAT_CYCLES`=20, `peak_cnt`=8: hold next for 200 cycles after acceptance → 1 + 1 + 5 = 7 index increments.
